// File: rtl/audio_i2s_pkg.sv
// Shared constants and types for the codec I2S capture and playback paths.
// Word widths are common to the ADC receiver and the DAC driver.
package audio_i2s_pkg;

   localparam int BIT_CNT_W = 6;

   localparam int AUD_W16 = 16;
   localparam int AUD_W24 = 24;
   localparam int AUD_W32 = 32;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } ch_sel_e;

endpackage

// File: rtl/audio_i2s_receiver_if.sv
// Codec ADC pins plus the captured stereo sample bus.
// master = the receiver, slave = the synth engine and the codec pads.
interface audio_i2s_receiver_if #(
   parameter int DATA_W = 24
);

   logic              iAUD_BCLK;
   logic              iAUD_ADCLRCK;
   logic              iAUD_ADCDAT;
   logic              i_err_clr;
   logic [DATA_W-1:0] o_lsound_in;
   logic [DATA_W-1:0] o_rsound_in;
   logic              o_sample_valid;
   logic              o_frame_err;

   modport master (
      input  iAUD_BCLK,
      input  iAUD_ADCLRCK,
      input  iAUD_ADCDAT,
      input  i_err_clr,
      output o_lsound_in,
      output o_rsound_in,
      output o_sample_valid,
      output o_frame_err
   );

   modport slave (
      output iAUD_BCLK,
      output iAUD_ADCLRCK,
      output iAUD_ADCDAT,
      output i_err_clr,
      input  o_lsound_in,
      input  o_rsound_in,
      input  o_sample_valid,
      input  o_frame_err
   );

endinterface

// File: rtl/audio_i2s_receiver_sync.sv
// Brings the codec BCLK/LRCK/DAT into sys_clk and flags BCLK rises.
// All three outputs are registered so they stay aligned with bclk_rise.
module i2s_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic reset_reg,
   input  logic bclk,
   input  logic lrck,
   input  logic dat,
   output logic bclk_rise,
   output logic lrck_s,
   output logic dat_s
);

   logic [SYNC_STAGES-1:0] bclk_q;
   logic [SYNC_STAGES-1:0] lrck_q;
   logic [SYNC_STAGES-1:0] dat_q;
   logic                   bclk_prev;

   always_ff @(posedge sys_clk or posedge reset_reg) begin
      if (reset_reg) begin
         bclk_q    <= '0;
         lrck_q    <= '0;
         dat_q     <= '0;
         bclk_prev <= 1'b0;
         bclk_rise <= 1'b0;
         lrck_s    <= 1'b0;
         dat_s     <= 1'b0;
      end else begin
         bclk_q    <= {bclk_q[SYNC_STAGES-2:0], bclk};
         lrck_q    <= {lrck_q[SYNC_STAGES-2:0], lrck};
         dat_q     <= {dat_q[SYNC_STAGES-2:0], dat};
         bclk_prev <= bclk_q[SYNC_STAGES-1];
         bclk_rise <= bclk_q[SYNC_STAGES-1] & ~bclk_prev;
         lrck_s    <= lrck_q[SYNC_STAGES-1];
         dat_s     <= dat_q[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/audio_i2s_receiver.sv
// I2S slave receiver for the codec ADC: deserialises L/R words MSB-first
// and presents each complete stereo pair with a one-cycle valid strobe.
import audio_i2s_pkg::*;

module audio_i2s_receiver #(
   parameter int DATA_W      = AUD_W24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 sys_clk,
   input  logic                 reset_reg,
   audio_i2s_receiver_if.master aud
);

   localparam logic [BIT_CNT_W:0] DW_N = (BIT_CNT_W+1)'(DATA_W);

   logic bclk_rise;
   logic lrck_s;
   logic dat_s;

   i2s_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .sys_clk   (sys_clk),
      .reset_reg (reset_reg),
      .bclk      (aud.iAUD_BCLK),
      .lrck      (aud.iAUD_ADCLRCK),
      .dat       (aud.iAUD_ADCDAT),
      .bclk_rise (bclk_rise),
      .lrck_s    (lrck_s),
      .dat_s     (dat_s)
   );

   ch_sel_e              lrck_prev;
   logic                 lr_vld;
   logic                 armed;
   logic                 left_ok;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [DATA_W-1:0]    shreg;
   logic [DATA_W-1:0]    stage_l;
   logic [DATA_W-1:0]    lsound;
   logic [DATA_W-1:0]    rsound;
   logic                 valid;
   logic                 frame_err;

   logic                 shift_en;
   logic [DATA_W-1:0]    word;
   logic [BIT_CNT_W:0]   n_bits;
   logic                 edge_det;
   logic                 short_slot;
   logic                 err_set;

   // lr_vld keeps the first LRCK seen after reset from counting as an edge
   always_comb begin
      shift_en   = {1'b0, bit_cnt} < DW_N;
      word       = shift_en ? {shreg[DATA_W-2:0], dat_s} : shreg;
      n_bits     = {1'b0, bit_cnt} + {{BIT_CNT_W{1'b0}}, shift_en};
      short_slot = n_bits < DW_N;
      edge_det   = bclk_rise & lr_vld & (lrck_s != lrck_prev);
      err_set    = edge_det & armed & short_slot;
   end

   always_ff @(posedge sys_clk or posedge reset_reg) begin
      if (reset_reg) begin
         lrck_prev <= CH_LEFT;
         lr_vld    <= 1'b0;
         armed     <= 1'b0;
         left_ok   <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         stage_l   <= '0;
         lsound    <= '0;
         rsound    <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (err_set) begin
            frame_err <= 1'b1;
         end else if (aud.i_err_clr) begin
            frame_err <= 1'b0;
         end
         if (bclk_rise) begin
            lr_vld    <= 1'b1;
            lrck_prev <= ch_sel_e'(lrck_s);
            shreg     <= word;
            if (edge_det) begin
               bit_cnt <= '0;
            end else if (bit_cnt != '1) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
            // the edge-cycle bit is the LSB of the slot being closed
            if (edge_det) begin
               if (!armed) begin
                  armed <= 1'b1;
               end else if (lrck_prev == CH_LEFT) begin
                  if (short_slot) begin
                     left_ok <= 1'b0;
                  end else begin
                     stage_l <= word;
                     left_ok <= 1'b1;
                  end
               end else begin
                  if (!short_slot && left_ok) begin
                     lsound <= stage_l;
                     rsound <= word;
                     valid  <= 1'b1;
                  end
                  left_ok <= 1'b0;
               end
            end
         end
      end
   end

   assign aud.o_lsound_in    = lsound;
   assign aud.o_rsound_in    = rsound;
   assign aud.o_sample_valid = valid;
   assign aud.o_frame_err    = frame_err;

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Directed bench: three receivers (24b/2 sync, 24b/3 sync, 16b/2 sync)
// share one codec pin set driven as a linear sequence of frames.
module tb_audio_i2s_receiver;

   logic sys_clk = 1'b0;
   logic reset_reg = 1'b1;
   logic bclk = 1'b0;
   logic lrck = 1'b0;
   logic dat = 1'b0;
   logic clr24 = 1'b0;
   logic clr3 = 1'b0;
   logic clr16 = 1'b0;

   int checks = 0;
   int fails = 0;
   int nv24 = 0;
   int nv3 = 0;
   int nv16 = 0;
   int lat24 = 0;
   int lat3 = 0;
   int base = 0;
   bit jit = 1'b0;
   logic last_bit = 1'b0;

   always #5 sys_clk = ~sys_clk;

   audio_i2s_receiver_if #(.DATA_W(24)) b24 ();
   audio_i2s_receiver_if #(.DATA_W(24)) b3 ();
   audio_i2s_receiver_if #(.DATA_W(16)) b16 ();

   assign b24.iAUD_BCLK    = bclk;
   assign b24.iAUD_ADCLRCK = lrck;
   assign b24.iAUD_ADCDAT  = dat;
   assign b24.i_err_clr    = clr24;
   assign b3.iAUD_BCLK     = bclk;
   assign b3.iAUD_ADCLRCK  = lrck;
   assign b3.iAUD_ADCDAT   = dat;
   assign b3.i_err_clr     = clr3;
   assign b16.iAUD_BCLK    = bclk;
   assign b16.iAUD_ADCLRCK = lrck;
   assign b16.iAUD_ADCDAT  = dat;
   assign b16.i_err_clr    = clr16;

   audio_i2s_receiver #(.DATA_W(24), .SYNC_STAGES(2)) dut24 (
      .sys_clk   (sys_clk),
      .reset_reg (reset_reg),
      .aud       (b24)
   );

   audio_i2s_receiver #(.DATA_W(24), .SYNC_STAGES(3)) dut3 (
      .sys_clk   (sys_clk),
      .reset_reg (reset_reg),
      .aud       (b3)
   );

   audio_i2s_receiver #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
      .sys_clk   (sys_clk),
      .reset_reg (reset_reg),
      .aud       (b16)
   );

   always @(posedge sys_clk) begin
      if (b24.o_sample_valid === 1'b1) nv24 <= nv24 + 1;
      if (b3.o_sample_valid === 1'b1) nv3 <= nv3 + 1;
      if (b16.o_sample_valid === 1'b1) nv16 <= nv16 + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic bit_of(input logic [31:0] w, input int width,
                                   input int j);
      logic [31:0] t;
      t = w;
      return (j < width) ? t[width-1-j] : 1'b0;
   endfunction

   // One slot of len BCLKs; data lags LRCK by one BCLK (I2S framing).
   task automatic send_slot(input logic lr, input logic [31:0] w,
                            input int width, input int len,
                            input int stop_at = -1,
                            input bit clr_edge = 1'b0,
                            input bit meas = 1'b0);
      int lo;
      int hi;
      for (int i = 0; i < len; i++) begin
         lo = jit ? int'($urandom_range(5, 3)) : 4;
         hi = jit ? int'($urandom_range(5, 3)) : 4;
         bclk = 1'b0;
         lrck = lr;
         dat  = (i == 0) ? last_bit : bit_of(w, width, i - 1);
         tick(lo);
         bclk = 1'b1;
         if (meas && i == 0) begin
            lat24 = 0;
            lat3  = 0;
            for (int k = 1; k <= 10; k++) begin
               tick(1);
               if (lat24 == 0 && b24.o_sample_valid === 1'b1) lat24 = k;
               if (lat3 == 0 && b3.o_sample_valid === 1'b1) lat3 = k;
            end
         end else if (clr_edge && i == 0) begin
            tick(3);
            clr24 = 1'b1;
            tick(1);
            clr24 = 1'b0;
         end else begin
            tick(hi);
         end
         if (i == stop_at) begin
            base = nv24;
            tick(1000);
            chk("stop_no_valid", nv24, base);
         end
      end
      last_bit = bit_of(w, width, len - 1);
   endtask

   initial begin
      // power-up reset
      tick(3);
      reset_reg = 1'b0;
      tick(2);
      chk("rst_l", b24.o_lsound_in, 24'h0);
      chk("rst_r", b24.o_rsound_in, 24'h0);
      chk("rst_valid", b24.o_sample_valid, 1'b0);
      chk("rst_err", b24.o_frame_err, 1'b0);
      chk("rst_l16", b16.o_lsound_in, 16'h0);

      // standard 32-BCLK frames; first pair needs full L + R after arming
      send_slot(0, 24'h800001, 24, 32);
      send_slot(1, 24'h7FFFFE, 24, 32);
      send_slot(0, 24'h800001, 24, 32);
      send_slot(1, 24'h7FFFFE, 24, 32);
      send_slot(0, 24'h123456, 24, 32);
      chk("std_cnt", nv24, 1);
      chk("std_l", b24.o_lsound_in, 24'h800001);
      chk("std_r", b24.o_rsound_in, 24'h7FFFFE);
      chk("std_l_ss3", b3.o_lsound_in, 24'h800001);
      chk("std_r_ss3", b3.o_rsound_in, 24'h7FFFFE);
      send_slot(1, 24'h654321, 24, 32);
      send_slot(0, 24'h0ABCDE, 24, 32);
      chk("std2_cnt", nv24, 2);
      chk("std2_l", b24.o_lsound_in, 24'h123456);
      chk("std2_r", b24.o_rsound_in, 24'h654321);
      chk("std2_cnt_ss3", nv3, 2);

      // reset in the middle of an R slot
      send_slot(1, 24'hFFFFFF, 24, 16);
      reset_reg = 1'b1;
      tick(2);
      reset_reg = 1'b0;
      tick(1);
      chk("mid_rst_l", b24.o_lsound_in, 24'h0);
      chk("mid_rst_r", b24.o_rsound_in, 24'h0);
      chk("mid_rst_valid", b24.o_sample_valid, 1'b0);
      chk("mid_rst_err", b24.o_frame_err, 1'b0);
      base = nv24;
      send_slot(1, 24'h000000, 24, 16);
      send_slot(0, 24'h111111, 24, 32);
      send_slot(1, 24'h222222, 24, 32);
      send_slot(0, 24'h333333, 24, 32);
      chk("post_rst_cnt", nv24 - base, 1);
      chk("post_rst_l", b24.o_lsound_in, 24'h111111);
      chk("post_rst_r", b24.o_rsound_in, 24'h222222);
      chk("post_rst_err", b24.o_frame_err, 1'b0);

      // short 20-BCLK left slot
      base = nv24;
      send_slot(1, 24'h444444, 24, 32);
      send_slot(0, 24'h555555, 24, 20);
      send_slot(1, 24'h666666, 24, 32);
      send_slot(0, 24'h777777, 24, 32);
      chk("short_cnt", nv24 - base, 1);
      chk("short_l_hold", b24.o_lsound_in, 24'h333333);
      chk("short_r_hold", b24.o_rsound_in, 24'h444444);
      chk("short_err", b24.o_frame_err, 1'b1);
      send_slot(1, 24'h888888, 24, 32);
      send_slot(0, 24'h999999, 24, 32);
      chk("after_short_cnt", nv24 - base, 2);
      chk("after_short_l", b24.o_lsound_in, 24'h777777);
      chk("after_short_r", b24.o_rsound_in, 24'h888888);
      chk("err_sticky", b24.o_frame_err, 1'b1);
      clr24 = 1'b1;
      tick(1);
      clr24 = 1'b0;
      tick(1);
      chk("err_clr", b24.o_frame_err, 1'b0);

      // short R slot closing in the same cycle as an error clear
      base = nv24;
      send_slot(1, 24'hAAAAAA, 24, 20);
      send_slot(0, 24'hBBBBBB, 24, 32, -1, 1'b1);
      chk("set_wins", b24.o_frame_err, 1'b1);
      chk("short_r_no_valid", nv24 - base, 0);
      clr24 = 1'b1;
      tick(1);
      clr24 = 1'b0;
      tick(1);
      chk("err_clr2", b24.o_frame_err, 1'b0);

      // BCLK stopped for 1000 sys_clk mid-slot
      base = nv24;
      send_slot(1, 24'hCCCCCC, 24, 32, 10);
      send_slot(0, 24'hDDDDDD, 24, 32);
      chk("stop_cnt", nv24 - base, 1);
      chk("stop_l", b24.o_lsound_in, 24'hBBBBBB);
      chk("stop_r", b24.o_rsound_in, 24'hCCCCCC);

      // latency with jittered BCLK
      jit = 1'b1;
      send_slot(1, 24'hEEEEEE, 24, 32);
      send_slot(0, 24'hFFFFFF, 24, 32, -1, 1'b0, 1'b1);
      chk("lat_ss2_a", lat24, 4);
      chk("lat_ss3_a", lat3, 5);
      chk("jit_l", b24.o_lsound_in, 24'hDDDDDD);
      chk("jit_r", b3.o_rsound_in, 24'hEEEEEE);
      send_slot(1, 24'h0F0F0F, 24, 32);
      send_slot(0, 24'h00FF00, 24, 32, -1, 1'b0, 1'b1);
      chk("lat_ss2_b", lat24, 4);
      chk("lat_ss3_b", lat3, 5);
      chk("jit2_l", b3.o_lsound_in, 24'hFFFFFF);
      chk("jit2_r", b24.o_rsound_in, 24'h0F0F0F);
      jit = 1'b0;

      // exact-width 16-BCLK slots on the 16-bit receiver
      send_slot(1, 16'h0000, 16, 16);
      send_slot(0, 16'hA5C3, 16, 16);
      send_slot(1, 16'h0001, 16, 16);
      base = nv16;
      send_slot(0, 16'h0000, 16, 16);
      chk("w16_cnt", nv16 - base, 1);
      chk("w16_l", b16.o_lsound_in, 16'hA5C3);
      chk("w16_r", b16.o_rsound_in, 16'h0001);
      chk("w16_err", b16.o_frame_err, 1'b0);
      chk("w16_on_24_err", b24.o_frame_err, 1'b1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
